// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch-stage constants and the next-PC select encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int unsigned c_pc_width = 32;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_RET    = 3'd3,
        NPC_HOLD   = 3'd4
    } npc_sel_t;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return-address stack with push/pop/replace and a
//            sticky overflow flag.
// Revision : 1.0
// ============================================================================
module ras_stack #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [PC_WIDTH-1:0]        i_push_data,
    output logic [PC_WIDTH-1:0]        o_top,
    output logic [$clog2(RAS_DEPTH):0] o_count,
    output logic                       o_empty,
    output logic                       o_overflow
);

    localparam int unsigned          c_ptr_w = $clog2(RAS_DEPTH);
    localparam int unsigned          c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_full  = c_cnt_w'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0]  r_top;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_overflow;

    logic [c_ptr_w-1:0]  w_top_inc;
    logic [c_ptr_w-1:0]  w_top_dec;
    logic [c_ptr_w-1:0]  w_waddr;
    logic                w_empty;
    logic                w_full;
    logic                w_replace;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full);
    assign w_top_inc = r_top + 1'b1;
    assign w_top_dec = r_top - 1'b1;
    // Push and pop together on a non-empty stack rewrite the top in place;
    // on an empty stack the pair degenerates into a plain push.
    assign w_replace = i_push & i_pop & ~w_empty;
    assign w_waddr   = w_replace ? r_top : w_top_inc;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_waddr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_push && !w_replace) begin
            // When full the pointer lands on the oldest entry, overwriting it.
            r_top <= w_top_inc;
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop && !i_push && !w_empty) begin
            r_top   <= w_top_dec;
            r_count <= r_count - 1'b1;
        end
    end

    assign o_top      = r_mem[r_top];
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

    a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= c_full);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-stage PC register with prioritised next-PC selection and a
//            return-address stack for jr $ra.
// Revision : 1.0
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = c_pc_width,
    parameter int unsigned          RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(c_reset_pc)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Stall,
    input  logic                       BranchTaken,
    input  logic [PC_WIDTH-1:0]        BranchTarget,
    input  logic                       Jump,
    input  logic [PC_WIDTH-1:0]        JumpTarget,
    input  logic                       JumpLink,
    input  logic [PC_WIDTH-1:0]        LinkAddr,
    input  logic                       JumpReturn,
    output logic [PC_WIDTH-1:0]        PCResult,
    output logic [PC_WIDTH-1:0]        PCAddResult,
    output logic [$clog2(RAS_DEPTH):0] RASCount,
    output logic                       RASMiss,
    output logic                       RASOverflow
);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_ras_miss;

    npc_sel_t            w_sel;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic                w_ras_empty;
    logic                w_active;
    logic                w_push;
    logic                w_pop;

    // Branch and stall both suppress every RAS side effect of ID-stage jumps.
    assign w_active = ~BranchTaken & ~Stall;
    assign w_pop    = w_active & JumpReturn;
    assign w_push   = w_active & Jump & JumpLink;

    always_comb begin
        w_sel = NPC_SEQ;
        if (BranchTaken) begin
            w_sel = NPC_BRANCH;
        end else if (Stall) begin
            w_sel = NPC_HOLD;
        end else if (JumpReturn) begin
            w_sel = NPC_RET;
        end else if (Jump) begin
            w_sel = NPC_JUMP;
        end
    end

    always_comb begin
        w_next_pc = PCAddResult;
        case (w_sel)
            NPC_BRANCH: w_next_pc = BranchTarget;
            NPC_HOLD:   w_next_pc = r_pc;
            NPC_RET:    w_next_pc = w_ras_empty ? JumpTarget : w_ras_top;
            NPC_JUMP:   w_next_pc = JumpTarget;
            default:    w_next_pc = PCAddResult;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc       <= RESET_PC;
            r_ras_miss <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_ras_miss <= (w_sel == NPC_RET) && w_ras_empty;
        end
    end

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (Clk),
        .rst         (Reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (LinkAddr),
        .o_top       (w_ras_top),
        .o_count     (RASCount),
        .o_empty     (w_ras_empty),
        .o_overflow  (RASOverflow)
    );

    assign PCResult    = r_pc;
    assign PCAddResult = r_pc + 1'b1;
    assign RASMiss     = r_ras_miss;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer against a queue-based RAS model.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam int unsigned c_depth = 4;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        miss;
        logic        ovf;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        JumpLink = 1'b0;
    logic [31:0] LinkAddr = '0;
    logic        JumpReturn = 1'b0;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic [2:0]  RASCount;
    logic        RASMiss;
    logic        RASOverflow;

    pc_sequencer #(
        .PC_WIDTH  (32),
        .RAS_DEPTH (c_depth),
        .RESET_PC  (32'h0)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .JumpLink     (JumpLink),
        .LinkAddr     (LinkAddr),
        .JumpReturn   (JumpReturn),
        .PCResult     (PCResult),
        .PCAddResult  (PCAddResult),
        .RASCount     (RASCount),
        .RASMiss      (RASMiss),
        .RASOverflow  (RASOverflow)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb_q[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_ras[$];
    logic        m_ovf = 1'b0;
    logic        m_miss = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [31:0] la);
        m_ras.push_back(la);
        if (m_ras.size() > c_depth) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    // One clock: drive at negedge, predict, then compare just after posedge.
    task automatic cyc(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                       input logic j, input logic jl, input logic [31:0] jt,
                       input logic [31:0] la, input logic jr);
        exp_t e;
        @(negedge Clk);
        Reset = rst; Stall = stl; BranchTaken = br; BranchTarget = bt;
        Jump = j; JumpLink = jl; JumpTarget = jt; LinkAddr = la; JumpReturn = jr;
        m_miss = 1'b0;
        if (rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_ovf = 1'b0;
        end else if (br) begin
            m_pc = bt;
        end else if (!stl) begin
            if (jr) begin
                if (m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    m_pc   = jt;
                    m_miss = 1'b1;
                end
                if (j && jl) model_push(la);
            end else if (j) begin
                m_pc = jt;
                if (jl) model_push(la);
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end
        e.pc = m_pc; e.cnt = 3'(m_ras.size()); e.miss = m_miss; e.ovf = m_ovf;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        check("pc", PCResult, e.pc);
        check("pcadd", PCAddResult, e.pc + 32'd1);
        check("ras_count", {29'b0, RASCount}, {29'b0, e.cnt});
        check("ras_miss", {31'b0, RASMiss}, {31'b0, e.miss});
        check("ras_ovf", {31'b0, RASOverflow}, {31'b0, e.ovf});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic branch(input logic [31:0] bt);
        cyc(0, 0, 1, bt, 0, 0, 0, 0, 0);
    endtask

    task automatic jal(input logic [31:0] jt, input logic [31:0] la);
        cyc(0, 0, 0, 0, 1, 1, jt, la, 0);
    endtask

    task automatic ret(input logic [31:0] jt);
        cyc(0, 0, 0, 0, 0, 0, jt, 0, 1);
    endtask

    initial begin
        // Reset and free-running increment
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", PCResult, 32'h0);
        check("reset_cnt", {29'b0, RASCount}, 32'h0);
        for (int i = 0; i < 3; i++) idle();
        check("seq_pc3", PCResult, 32'h3);
        check("seq_add4", PCAddResult, 32'h4);

        // jal then jr through the RAS
        branch(32'h10);
        jal(32'h40, 32'h11);
        check("jal_pc", PCResult, 32'h40);
        check("jal_cnt", {29'b0, RASCount}, 32'h1);
        for (int i = 0; i < 3; i++) idle();
        ret(32'h999);
        check("ret_pc", PCResult, 32'h11);
        check("ret_miss", {31'b0, RASMiss}, 32'h0);

        // Return on empty RAS falls back and pulses miss once
        ret(32'h80);
        check("miss_pc", PCResult, 32'h80);
        check("miss_pulse", {31'b0, RASMiss}, 32'h1);
        idle();
        check("miss_clear", {31'b0, RASMiss}, 32'h0);

        // Overflow: five pushes into four entries
        for (int i = 1; i <= 5; i++) jal(32'h100, 32'(i));
        check("ovf_cnt", {29'b0, RASCount}, 32'h4);
        check("ovf_flag", {31'b0, RASOverflow}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            ret(32'h300);
            check("ovf_ret", PCResult, 32'(5 - i));
        end
        ret(32'h300);
        check("ovf_ret_miss", {31'b0, RASMiss}, 32'h1);

        // Simultaneous push+pop: replace top; empty case pushes one entry
        jal(32'h500, 32'h55);
        cyc(0, 0, 0, 0, 1, 1, 32'h600, 32'h66, 1);
        check("repl_pc", PCResult, 32'h55);
        ret(32'h700);
        check("repl_top", PCResult, 32'h66);
        cyc(0, 0, 0, 0, 1, 1, 32'h610, 32'h77, 1);
        ret(32'h710);
        check("repl_empty", PCResult, 32'h77);

        // Branch overrides stall and squashes jal; stall then holds
        jal(32'h20, 32'h21);
        cyc(0, 1, 1, 32'h200, 1, 1, 32'h40, 32'h99, 0);
        check("br_stall_pc", PCResult, 32'h200);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 32'h44, 32'h45, 1);
        check("stall_hold", PCResult, 32'h200);
        check("stall_cnt", {29'b0, RASCount}, 32'h1);

        // JumpLink without Jump is ignored
        cyc(0, 0, 0, 0, 0, 1, 32'h30, 32'h31, 0);
        check("jl_only_pc", PCResult, 32'h201);

        // Wrap at all-ones
        branch(32'hFFFF_FFFF);
        check("wrap_add", PCAddResult, 32'h0);
        idle();
        check("wrap_pc", PCResult, 32'h0);

        // Reset during a jal discards the request
        cyc(1, 0, 0, 0, 1, 1, 32'h40, 32'h41, 0);
        check("rst_jump_pc", PCResult, 32'h0);
        check("rst_ovf", {31'b0, RASOverflow}, 32'h0);

        // Random mix of controls
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0), $urandom,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), $urandom,
                $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage program-counter register. It consumes the PC+1 increment and redirect targets, and produces the fetch address each cycle.
- It is the register and next-PC side of the PC increment path. PC is word-addressed: sequential step is +1.
- Includes a small return-address stack (RAS) so that jump-register returns redirect without waiting on the register file value.
- Sits between the instruction-memory address port and the ID/EX redirect logic.

Parameters:
- PC_WIDTH, 32, width of PC and all target/address buses.
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard stall from ID; hold PC and RAS.
- BranchTaken  in  1  EX-stage resolved taken branch.
- BranchTarget  in  PC_WIDTH  branch destination (word address).
- Jump  in  1  ID-stage unconditional jump (j/jal).
- JumpTarget  in  PC_WIDTH  jump destination; also the fallback target for returns.
- JumpLink  in  1  qualifies Jump as jal: push LinkAddr.
- LinkAddr  in  PC_WIDTH  return address to push (jal PC+1).
- JumpReturn  in  1  ID-stage jr $ra: pop RAS.
- PCResult  out  PC_WIDTH  current fetch address (registered).
- PCAddResult  out  PC_WIDTH  PCResult+1, combinational.
- RASCount  out  $clog2(RAS_DEPTH)+1  valid entries.
- RASMiss  out  1  one-cycle pulse: return with empty RAS (fallback used).
- RASOverflow  out  1  sticky: push occurred while full; cleared by Reset only.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - PCResult=RESET_PC; RASCount=0; RASMiss=0; RASOverflow=0.
  - RAS storage contents are don't-care.
  - Reset asserted mid-redirect or mid-stall discards all pending inputs that cycle.
- Next-PC priority (highest first, evaluated each edge when Reset=0):
  1. BranchTaken: PC←BranchTarget. Overrides Stall. Any same-cycle Jump/JumpReturn is squashed: no RAS push/pop, no RASMiss.
  2. Stall: PC, RAS and RASCount hold. RASMiss=0.
  3. JumpReturn:
     - RASCount>0: PC←top entry; pop.
     - RASCount==0: PC←JumpTarget; RASMiss=1 for exactly one cycle.
  4. Jump: PC←JumpTarget; if JumpLink, push LinkAddr.
  5. Otherwise PC←PCAddResult.
- Arithmetic:
  - PCAddResult = PCResult + 1, modulo 2^PC_WIDTH.
  - All-ones wraps to 0 with no flag.
- Latency:
  - Redirects take effect on PCResult the cycle after the request edge.
  - PCAddResult tracks PCResult combinationally (zero cycle).
- RAS organisation: circular buffer with top pointer.
  - Push when full overwrites the oldest entry, RASCount stays RAS_DEPTH, RASOverflow←1.
  - Pop when empty: see rule 3 above; the pointer does not move.
- Simultaneous push+pop (JumpReturn and Jump&JumpLink both asserted):
  - JumpReturn takes PC priority.
  - RAS top is replaced by LinkAddr, RASCount unchanged.
  - If the RAS was empty, the entry is written and RASCount becomes 1.
- Illegal-but-tolerated input: JumpLink without Jump is ignored.
- Assertions for the verifier:
  - RASCount ≤ RAS_DEPTH always.
  - PCResult changes only per the priority list.

Decomposition:
- Shared package (cpu_pkg):
  - PC_WIDTH default.
  - RESET_PC.
  - Next-PC select enum {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_RET, NPC_HOLD}.
- One sub-module is natural: ras_stack (push/pop/replace, count, overflow). It is parameterised by RAS_DEPTH and PC_WIDTH.
- Next-PC selection and the PC register stay in pc_sequencer.

Test Plan:
- Reset then 3 free-running cycles → PCResult 0,1,2,3; PCAddResult 1,2,3,4; RASCount=0.
- PC=0x10, Jump=1, JumpLink=1, JumpTarget=0x40, LinkAddr=0x11 → next PC=0x40, RASCount=1. Three cycles later JumpReturn=1 → PC=0x11, RASCount=0, RASMiss=0.
- Empty RAS, JumpReturn=1, JumpTarget=0x80 → PC=0x80, RASMiss high for 1 cycle, RASCount stays 0.
- Five jal pushes (LinkAddr 1..5) with RAS_DEPTH=4 → RASCount=4, RASOverflow=1. Four returns yield PCs 5,4,3,2; a fifth return misses.
- Stall=1 with BranchTaken=1, BranchTarget=0x200, Jump=1, JumpLink=1 same cycle → PC=0x200, no push (RASCount unchanged). Stall alone for 2 cycles holds PC=0x200.
- PC forced to 0xFFFFFFFF via BranchTarget → next PC=0x00000000. Reset asserted during a Jump cycle → PC=RESET_PC, RASCount=0.
